// File: rtl/prbs31_pkg.sv
// PRBS31 constants, FSM state type and seed helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prbs31_pkg;

    localparam int PRBS_W = 31;
    localparam int TAP_HI = 30;
    localparam int TAP_LO = 27;
    localparam logic [PRBS_W-1:0] DEFAULT_SEED = 31'h7FFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SYNC,
        CHECK,
        DONE
    } bert_state_t;

    // An all-zero LFSR never leaves zero, so substitute the all-ones seed.
    function automatic logic [PRBS_W-1:0] seed_fix(input logic [PRBS_W-1:0] s);
        return (s == '0) ? DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/prbs31_bert_ctrl_if.sv
// Control, status and loopback signals of the PRBS31 BERT controller.
// Latency: n/a (wiring only).
// Backpressure: none; rx_valid qualifies rx_bit, tx_valid qualifies tx_bit.
interface prbs31_bert_ctrl_if
    import prbs31_pkg::*;
#(
    parameter int LEN_W = 32,
    parameter int ERR_W = 16
);
    logic              start;
    logic              abort;
    logic [PRBS_W-1:0] seed;
    logic [LEN_W-1:0]  test_len;
    logic              inj_err;
    logic              rx_bit;
    logic              rx_valid;
    logic              tx_bit;
    logic              tx_valid;
    logic              busy;
    logic              locked;
    logic              done;
    logic [ERR_W-1:0]  err_cnt;
    logic [LEN_W-1:0]  bit_cnt;

    modport master (
        output start, abort, seed, test_len, inj_err, rx_bit, rx_valid,
        input  tx_bit, tx_valid, busy, locked, done, err_cnt, bit_cnt
    );

    modport slave (
        input  start, abort, seed, test_len, inj_err, rx_bit, rx_valid,
        output tx_bit, tx_valid, busy, locked, done, err_cnt, bit_cnt
    );
endinterface

// File: rtl/prbs31_lfsr.sv
// 31-bit shift register for x^31+x^28+1: self-feedback (generator) or external bit (checker).
// Latency: state updates one cycle after load/shift; pred is combinational from state.
// Backpressure: none; holds state when neither load nor shift.
module prbs31_lfsr
    import prbs31_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [PRBS_W-1:0] load_val,
    input  logic              shift,
    input  logic              shift_in_sel,
    input  logic              ext_bit,
    output logic [PRBS_W-1:0] state,
    output logic              pred
);

    assign pred = state[TAP_HI] ^ state[TAP_LO];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (shift) begin
            state <= {state[PRBS_W-2:0], (shift_in_sel ? ext_bit : pred)};
        end
    end

endmodule

// File: rtl/prbs31_bert_ctrl.sv
// PRBS31 bit-error-rate test sequencer: generator, self-synchronising checker, counters.
// Latency: first tx_bit (seed[30]) in the first SYNC cycle, two cycles after start.
// Backpressure: none; rx side is qualified by rx_valid, gaps simply stall sync/count.
module prbs31_bert_ctrl
    import prbs31_pkg::*;
#(
    parameter int LEN_W    = 32,
    parameter int ERR_W    = 16,
    parameter int LOCK_THR = 4
) (
    input  logic               clk,
    input  logic               rst,
    prbs31_bert_ctrl_if.slave  bus
);

    localparam logic [4:0] SYNC_LAST = 5'd30;
    localparam logic [4:0] LOCK_LAST = 5'(LOCK_THR - 1);

    bert_state_t       state, next_state;
    logic [LEN_W-1:0]  len_q;
    logic [4:0]        sync_cnt;
    logic [4:0]        miss_run;
    logic [ERR_W-1:0]  err_cnt;
    logic [LEN_W-1:0]  bit_cnt;
    logic [LEN_W-1:0]  bit_cnt_inc;
    logic              cnt_en;
    logic              mismatch;
    logic              tx_active;

    logic [PRBS_W-1:0] gen_state;
    logic              gen_pred;
    logic [PRBS_W-1:0] chk_state;
    logic              chk_pred;
    logic              unused_taps;

    assign tx_active   = (state == SYNC) || (state == CHECK);
    assign mismatch    = bus.rx_bit ^ chk_pred;
    assign bit_cnt_inc = bit_cnt + LEN_W'(1);

    always_comb begin
        next_state = state;
        cnt_en     = 1'b0;
        case (state)
            IDLE:  if (bus.start) next_state = LOAD;
            LOAD:  next_state = SYNC;
            SYNC:  if (bus.rx_valid && (sync_cnt == SYNC_LAST)) next_state = CHECK;
            CHECK: begin
                if (bit_cnt == len_q) begin
                    next_state = DONE;
                end else if (bus.rx_valid) begin
                    cnt_en = 1'b1;
                    // Run end outranks lock loss on the same bit.
                    if (bit_cnt_inc == len_q) begin
                        next_state = DONE;
                    end else if (mismatch && (miss_run == LOCK_LAST)) begin
                        next_state = SYNC;
                    end
                end
            end
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.abort) next_state = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            sync_cnt <= '0;
            miss_run <= '0;
            err_cnt  <= '0;
            bit_cnt  <= '0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && (next_state == LOAD)) begin
                len_q <= bus.test_len;
            end
            if (state == LOAD) begin
                sync_cnt <= '0;
                miss_run <= '0;
                err_cnt  <= '0;
                bit_cnt  <= '0;
            end
            if ((state == SYNC) && bus.rx_valid) begin
                sync_cnt <= (sync_cnt == SYNC_LAST) ? 5'd0 : sync_cnt + 5'd1;
            end
            if (cnt_en) begin
                bit_cnt  <= bit_cnt_inc;
                miss_run <= mismatch ? miss_run + 5'd1 : 5'd0;
                if (mismatch && !(&err_cnt)) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
                if (next_state == SYNC) begin
                    sync_cnt <= '0;
                    miss_run <= '0;
                end
            end
        end
    end

    prbs31_lfsr u_gen (
        .clk          (clk),
        .rst          (rst),
        .load         (state == LOAD),
        .load_val     (seed_fix(bus.seed)),
        .shift        (tx_active),
        .shift_in_sel (1'b0),
        .ext_bit      (1'b0),
        .state        (gen_state),
        .pred         (gen_pred)
    );

    // Checker learns from received bits only, so it re-locks after any corruption.
    prbs31_lfsr u_chk (
        .clk          (clk),
        .rst          (rst),
        .load         (state == LOAD),
        .load_val     ('0),
        .shift        (tx_active && bus.rx_valid),
        .shift_in_sel (1'b1),
        .ext_bit      (bus.rx_bit),
        .state        (chk_state),
        .pred         (chk_pred)
    );

    assign unused_taps = ^{gen_pred, gen_state[PRBS_W-2:0], chk_state};

    assign bus.tx_valid = tx_active;
    assign bus.tx_bit   = tx_active & (gen_state[TAP_HI] ^ bus.inj_err);
    assign bus.busy     = (state != IDLE);
    assign bus.locked   = (state == CHECK);
    assign bus.done     = (state == DONE);
    assign bus.err_cnt  = err_cnt;
    assign bus.bit_cnt  = bit_cnt;

endmodule

// File: tb/tb_prbs31_bert_ctrl.sv
// Randomised bench for prbs31_bert_ctrl against a bit-stream reference model.
module tb_prbs31_bert_ctrl;

    localparam int LEN_W    = 32;
    localparam int ERR_W    = 5;
    localparam int LOCK_THR = 4;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;
    localparam int BUDGET   = 6000;

    localparam int M_SYNC  = 0;
    localparam int M_CHECK = 1;
    localparam int M_DONE  = 2;

    logic clk;
    logic rst;

    prbs31_bert_ctrl_if #(.LEN_W(LEN_W), .ERR_W(ERR_W)) bus ();

    prbs31_bert_ctrl #(
        .LEN_W    (LEN_W),
        .ERR_W    (ERR_W),
        .LOCK_THR (LOCK_THR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: expected generator bits and received-bit history.
    bit          gen_bits[$];
    bit          rx_hist[$];
    logic [30:0] seed_eff;
    int          phase;
    int          sync_n;
    int          miss_n;
    int          errs;
    int          bits;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_bit"},   64'(bus.tx_bit),   64'd0);
        check({tag, "_tx_valid"}, 64'(bus.tx_valid), 64'd0);
        check({tag, "_busy"},     64'(bus.busy),     64'd0);
        check({tag, "_locked"},   64'(bus.locked),   64'd0);
        check({tag, "_done"},     64'(bus.done),     64'd0);
        check({tag, "_err_cnt"},  64'(bus.err_cnt),  64'd0);
        check({tag, "_bit_cnt"},  64'(bus.bit_cnt),  64'd0);
    endtask

    // What one cycle of received input does to the test, in bit-stream terms.
    task automatic model_update(input bit vld, input bit rb, input int len);
        int  m;
        bit  pred;
        bit  mis;
        if (phase == M_SYNC) begin
            if (vld) begin
                rx_hist.push_back(rb);
                sync_n++;
                if (sync_n == 31) begin
                    phase  = M_CHECK;
                    sync_n = 0;
                end
            end
        end else if (phase == M_CHECK) begin
            if (bits == len) begin
                phase = M_DONE;
            end else if (vld) begin
                m    = rx_hist.size();
                pred = rx_hist[m-31] ^ rx_hist[m-28];
                mis  = (rb != pred);
                if (mis && errs < ERR_MAX) errs++;
                bits++;
                miss_n = mis ? miss_n + 1 : 0;
                rx_hist.push_back(rb);
                if (bits == len) begin
                    phase = M_DONE;
                end else if (miss_n >= LOCK_THR) begin
                    phase  = M_SYNC;
                    miss_n = 0;
                    sync_n = 0;
                end
            end
        end
    endtask

    // mode: 0 loopback+inject, 1 inverted rx, 2 rx stuck at 0 once locked, 3 loopback with drops
    // kill: 0 none, 1 abort, 2 reset -- applied on the 20th CHECK cycle
    task automatic run_case(input logic [30:0] s, input int len, input int mode, input int kill);
        int cyc;
        int ccyc;
        int n;
        bit inj;
        bit e;
        bit rb;
        bit vld;
        bit was_locked;
        seed_eff = (s == 31'd0) ? 31'h7FFF_FFFF : s;
        gen_bits.delete();
        rx_hist.delete();
        phase = M_SYNC; sync_n = 0; miss_n = 0; errs = 0; bits = 0;
        n = 0; cyc = 0; ccyc = 0; was_locked = 1'b0;

        bus.seed     = s;
        bus.test_len = LEN_W'(len);
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        check("load_busy",  64'(bus.busy),     64'd1);
        check("load_txv",   64'(bus.tx_valid), 64'd0);
        check("load_lock",  64'(bus.locked),   64'd0);
        step();

        while (phase != M_DONE && cyc < BUDGET) begin
            check("txv",     64'(bus.tx_valid), 64'd1);
            check("locked",  64'(bus.locked),   64'(phase == M_CHECK));
            check("done",    64'(bus.done),     64'd0);
            check("err_cnt", 64'(bus.err_cnt),  64'(errs));
            check("bit_cnt", 64'(bus.bit_cnt),  64'(bits));
            if (kill != 0 && phase == M_CHECK && ccyc == 20) begin
                bus.inj_err  = 1'b0;
                bus.rx_valid = 1'b0;
                bus.start    = 1'b0;
                if (kill == 1) begin
                    bus.abort = 1'b1;
                    step();
                    bus.abort = 1'b0;
                    check("abort_busy", 64'(bus.busy),     64'd0);
                    check("abort_lock", 64'(bus.locked),   64'd0);
                    check("abort_txv",  64'(bus.tx_valid), 64'd0);
                    for (int i = 0; i < 5; i++) begin
                        check("abort_nodone", 64'(bus.done), 64'd0);
                        step();
                    end
                end else begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    check_all_zero("midrst");
                    step();
                    check("midrst_nodone", 64'(bus.done), 64'd0);
                end
                return;
            end
            was_locked  = was_locked | (phase == M_CHECK);
            inj         = (mode == 0 || mode == 3) && ($urandom_range(0, 59) == 0);
            bus.inj_err = inj;
            bus.start   = ($urandom_range(0, 39) == 0);
            #1;
            e = (n < 31) ? seed_eff[30-n] : (gen_bits[n-31] ^ gen_bits[n-28]);
            gen_bits.push_back(e);
            n++;
            check("tx_bit", 64'(bus.tx_bit), 64'(e ^ inj));
            vld = (mode == 3) ? ($urandom_range(0, 19) != 0) : 1'b1;
            rb  = e ^ inj;
            if (mode == 1) rb = ~rb;
            if (mode == 2 && was_locked) rb = 1'b0;
            bus.rx_bit   = rb;
            bus.rx_valid = vld;
            if (phase == M_CHECK) ccyc++;
            model_update(vld, rb, len);
            step();
            cyc++;
        end
        check("run_end", 64'(phase), 64'(M_DONE));

        bus.inj_err  = 1'b0;
        bus.rx_valid = 1'b0;
        bus.start    = 1'b1;
        check("done_pulse", 64'(bus.done),     64'd1);
        check("done_txv",   64'(bus.tx_valid), 64'd0);
        check("done_busy",  64'(bus.busy),     64'd1);
        check("done_lock",  64'(bus.locked),   64'd0);
        check("done_err",   64'(bus.err_cnt),  64'(errs));
        check("done_bits",  64'(bus.bit_cnt),  64'(len));
        step();
        bus.start = 1'b0;
        check("idle_done", 64'(bus.done),    64'd0);
        check("idle_busy", 64'(bus.busy),    64'd0);
        check("held_err",  64'(bus.err_cnt), 64'(errs));
        check("held_bits", 64'(bus.bit_cnt), 64'(len));
        step();
        check("idle_stays", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.seed     = '0;
        bus.test_len = '0;
        bus.inj_err  = 1'b0;
        bus.rx_bit   = 1'b0;
        bus.rx_valid = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("post_reset");

        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_idle", 64'(bus.busy), 64'd0);
        step();
        check("start_abort_idle2", 64'(bus.busy), 64'd0);

        run_case(31'd0, 40, 0, 0);
        run_case(31'($urandom), 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            run_case(31'($urandom), int'($urandom_range(200, 1000)), 0, 0);
        end
        run_case(31'($urandom), 300, 3, 0);
        run_case(31'($urandom), 200, 1, 0);
        run_case(31'($urandom), 150, 2, 0);
        run_case(31'($urandom), 500, 0, 1);
        run_case(31'($urandom), 500, 0, 2);
        run_case(31'($urandom), 100, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
